// File: rtl/fill_pkg.sv
// Shared definitions for the memory fill unit: FSM states, source modes,
// fill depth, word width and LFSR constants.
package fill_pkg;

    localparam int unsigned DEPTH  = 512;
    localparam int unsigned DATA_W = 16;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'h0001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HANDOFF,
        S_DONE
    } state_t;

    typedef enum logic {
        MODE_STREAM = 1'b0,
        MODE_LFSR   = 1'b1
    } mode_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used as the pattern source of the fill unit.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load         : load seed (a zero seed is replaced by LFSR_SEED_DEFAULT)
//   enable       : advance one step
//   seed         : value loaded on load
//   value        : current LFSR state
module lfsr16 #(
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    import fill_pkg::*;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            // All-zero is the lock-up state of the LFSR, never load it
            value <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
        end else if (enable) begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/memory_fill_unit.sv
// Writer side of the data RAM shared with the run-search unit. Fills
// addresses 0..DEPTH-1 from a valid/ready stream or the LFSR pattern, then
// raises search_start and holds it until start drops.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   start          : level; high runs fill/handoff, low aborts to IDLE
//   mode, seed     : source select and LFSR seed, sampled in IDLE only
//   in_data/in_valid/in_ready : input stream handshake
//   write_enable/address/write_data : registered RAM write port
//   word_count     : words written since leaving IDLE
//   fill_done      : all DEPTH words written
//   search_start   : start level to the search unit
//   search_done    : completion from the search unit
module memory_fill_unit #(
    parameter int unsigned DEPTH     = fill_pkg::DEPTH,
    parameter int unsigned DATA_W    = fill_pkg::DATA_W,
    parameter logic [15:0] LFSR_TAPS = fill_pkg::LFSR_TAPS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [15:0]                  seed,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         write_enable,
    output logic [$clog2(DEPTH)-1:0]     address,
    output logic [DATA_W-1:0]            write_data,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic                         fill_done,
    output logic                         search_start,
    input  logic                         search_done
);
    import fill_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    state_t              state, state_n;
    mode_t               mode_q, mode_n;
    logic [CNT_W-1:0]    count_n;
    logic [ADDR_W-1:0]   address_n;
    logic [DATA_W-1:0]   write_data_n;
    logic                write_enable_n, in_ready_n, fill_done_n, search_start_n;
    logic                lfsr_load, lfsr_step, take;
    logic [15:0]         lfsr_value;

    lfsr16 #(.TAPS(LFSR_TAPS)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .load   (lfsr_load),
        .enable (lfsr_step),
        .seed   (seed),
        .value  (lfsr_value)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= MODE_STREAM;
            word_count   <= '0;
            write_enable <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            in_ready     <= 1'b0;
            fill_done    <= 1'b0;
            search_start <= 1'b0;
        end else begin
            state        <= state_n;
            mode_q       <= mode_n;
            word_count   <= count_n;
            write_enable <= write_enable_n;
            address      <= address_n;
            write_data   <= write_data_n;
            in_ready     <= in_ready_n;
            fill_done    <= fill_done_n;
            search_start <= search_start_n;
        end
    end

    // Pattern mode never stalls; stream mode relies on the registered
    // in_ready, which is already low once the count reaches DEPTH.
    assign take = (mode_q == MODE_LFSR) || (in_valid && in_ready);

    always_comb begin
        state_n        = state;
        mode_n         = mode_q;
        count_n        = word_count;
        address_n      = address;
        write_data_n   = write_data;
        write_enable_n = 1'b0;
        fill_done_n    = fill_done;
        search_start_n = search_start;
        lfsr_load      = 1'b0;
        lfsr_step      = 1'b0;

        if (!start) begin
            state_n        = S_IDLE;
            count_n        = '0;
            address_n      = '0;
            write_data_n   = '0;
            fill_done_n    = 1'b0;
            search_start_n = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n   = S_FILL;
                    mode_n    = mode_t'(mode);
                    lfsr_load = 1'b1;
                    count_n   = '0;
                end
                S_FILL: begin
                    if (word_count == FULL) begin
                        state_n        = S_HANDOFF;
                        fill_done_n    = 1'b1;
                        search_start_n = 1'b1;
                    end else if (take) begin
                        write_enable_n = 1'b1;
                        address_n      = word_count[ADDR_W-1:0];
                        write_data_n   = (mode_q == MODE_LFSR) ? DATA_W'(lfsr_value) : in_data;
                        count_n        = word_count + CNT_W'(1);
                        lfsr_step      = (mode_q == MODE_LFSR);
                    end
                end
                S_HANDOFF: begin
                    if (search_done) state_n = S_DONE;
                end
                S_DONE: begin
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Decoded from the next-state values so the handshake output stays registered
        in_ready_n = (state_n == S_FILL) && (mode_n == MODE_STREAM) && (count_n < FULL);
    end

endmodule
